// File: rtl/rob_pkg.sv
// Shared types, sizes and tag/index helpers for the reorder buffer.
// Tag 0 means "no producer"; entry i owns tag i+1.
package rob_pkg;

    localparam int unsigned ROB_SIZE = 16;
    localparam int unsigned TAG_W    = 5;
    localparam int unsigned IDX_W    = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;
    localparam int unsigned CNT_W    = $clog2(ROB_SIZE + 1);

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam tag_t TAG_NONE = '0;

    typedef struct packed {
        logic        busy;
        logic        ready;
        logic [4:0]  rd;
        logic [31:0] v;
        logic        mispredict;
        logic [31:0] target_pc;
    } rob_entry_t;

    function automatic tag_t idx_to_tag(input idx_t idx);
        return tag_t'(idx) + tag_t'(1);
    endfunction

    function automatic idx_t tag_to_idx(input tag_t tag);
        return idx_t'(tag - tag_t'(1));
    endfunction

    // Tags above ROB_SIZE do not name any entry and must never index the array.
    function automatic logic tag_in_range(input tag_t tag);
        return (tag != TAG_NONE) && (32'(tag) <= ROB_SIZE);
    endfunction

    function automatic idx_t idx_inc(input idx_t idx);
        return (32'(idx) == ROB_SIZE - 1) ? '0 : idx + idx_t'(1);
    endfunction

endpackage

// File: rtl/rob_query.sv
// Single operand-tag lookup into the reorder buffer entries.
// With ROB_QUERY_FWD_EN defined, a same-cycle CDB writeback is forwarded combinationally.
module rob_query
    import rob_pkg::*;
(
    input  tag_t        query_tag_i,
    input  rob_entry_t  entries_i [ROB_SIZE],
    input  logic        wb_flag_i,
    input  tag_t        wb_tag_i,
    input  logic [31:0] wb_v_i,
    output logic        ready_o,
    output logic [31:0] v_o
);

    rob_entry_t entry;

    always_comb begin
        ready_o = 1'b0;
        v_o     = '0;
        entry   = '0;
        if (tag_in_range(query_tag_i)) begin
            entry = entries_i[tag_to_idx(query_tag_i)];
            if (entry.busy) begin
                if (entry.ready) begin
                    ready_o = 1'b1;
                    v_o     = entry.v;
                end
`ifdef ROB_QUERY_FWD_EN
                if (wb_flag_i && (wb_tag_i == query_tag_i)) begin
                    ready_o = 1'b1;
                    v_o     = wb_v_i;
                end
`endif
            end
        end
    end

`ifndef ROB_QUERY_FWD_EN
    logic unused_wb;
    assign unused_wb = ^{wb_flag_i, wb_tag_i, wb_v_i};
`endif

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates rename tags, records CDB results, retires the head
// and flushes on a mispredicted branch. Optional same-cycle query forwarding: ROB_QUERY_FWD_EN.
module reorder_buffer
    import rob_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             en_signal_from_dispatcher,
    input  logic [4:0]       rd_from_dispatcher,
    input  logic             is_branch_from_dispatcher,
    output logic             full_to_dispatcher,
    output logic [TAG_W-1:0] Q_to_dispatcher,
    input  logic [TAG_W-1:0] Q1_query_from_dispatcher,
    input  logic [TAG_W-1:0] Q2_query_from_dispatcher,
    output logic             ready1_to_dispatcher,
    output logic             ready2_to_dispatcher,
    output logic [31:0]      V1_to_dispatcher,
    output logic [31:0]      V2_to_dispatcher,
    input  logic             wb_flag_from_cdb,
    input  logic [TAG_W-1:0] wb_Q_from_cdb,
    input  logic [31:0]      wb_V_from_cdb,
    input  logic             wb_mispredict_from_cdb,
    input  logic [31:0]      wb_target_pc_from_cdb,
    output logic             commit_flag_to_regfile,
    output logic [4:0]       rd_to_regfile,
    output logic [TAG_W-1:0] Q_to_regfile,
    output logic [31:0]      V_to_regfile,
    output logic             rollback_flag_to_all,
    output logic [31:0]      target_pc_to_fetch
);

    rob_entry_t  entries_q [ROB_SIZE];
    rob_entry_t  entries_d [ROB_SIZE];
    idx_t        head_q, head_d;
    idx_t        tail_q, tail_d;
    cnt_t        count_q, count_d;

    logic        commit_flag_q, commit_flag_d;
    logic [4:0]  commit_rd_q, commit_rd_d;
    tag_t        commit_tag_q, commit_tag_d;
    logic [31:0] commit_v_q, commit_v_d;
    logic        rollback_q, rollback_d;
    logic [31:0] target_pc_q, target_pc_d;

    logic        full;
    logic        do_alloc;
    logic        do_commit;
    logic        do_rollback;
    logic        wb_hit;
    idx_t        wb_idx;
    rob_entry_t  head_entry;

    // Branch-ness is implied by the CDB reporting a mispredict for that tag.
    logic unused_is_branch;
    assign unused_is_branch = is_branch_from_dispatcher;

    assign full            = (32'(count_q) == ROB_SIZE);
    assign head_entry      = entries_q[head_q];
    assign wb_idx          = tag_to_idx(wb_Q_from_cdb);

    always_comb begin
        do_alloc    = rdy_in && en_signal_from_dispatcher && !full;
        do_commit   = rdy_in && head_entry.busy && head_entry.ready;
        do_rollback = do_commit && head_entry.mispredict;
        wb_hit      = 1'b0;
        if (rdy_in && wb_flag_from_cdb && tag_in_range(wb_Q_from_cdb)) begin
            wb_hit = entries_q[wb_idx].busy;
        end
    end

    always_comb begin
        entries_d     = entries_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        commit_flag_d = 1'b0;
        rollback_d    = 1'b0;
        commit_rd_d   = commit_rd_q;
        commit_tag_d  = commit_tag_q;
        commit_v_d    = commit_v_q;
        target_pc_d   = target_pc_q;

        if (wb_hit) begin
            entries_d[wb_idx].ready      = 1'b1;
            entries_d[wb_idx].v          = wb_V_from_cdb;
            entries_d[wb_idx].mispredict = wb_mispredict_from_cdb;
            entries_d[wb_idx].target_pc  = wb_target_pc_from_cdb;
        end

        if (do_alloc) begin
            entries_d[tail_q].busy       = 1'b1;
            entries_d[tail_q].ready      = 1'b0;
            entries_d[tail_q].rd         = rd_from_dispatcher;
            entries_d[tail_q].v          = '0;
            entries_d[tail_q].mispredict = 1'b0;
            entries_d[tail_q].target_pc  = '0;
            tail_d                       = idx_inc(tail_q);
        end

        if (do_commit) begin
            entries_d[head_q].busy = 1'b0;
            head_d                 = idx_inc(head_q);
            commit_flag_d          = 1'b1;
            commit_rd_d            = head_entry.rd;
            commit_tag_d           = idx_to_tag(head_q);
            commit_v_d             = head_entry.v;
        end

        if (do_rollback) begin
            // Flush wins over any same-cycle allocate or writeback.
            rollback_d  = 1'b1;
            target_pc_d = head_entry.target_pc;
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries_d[i].busy = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            count_d = count_q + cnt_t'(do_alloc) - cnt_t'(do_commit);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            entries_q     <= '{default: '0};
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            commit_flag_q <= 1'b0;
            commit_rd_q   <= '0;
            commit_tag_q  <= '0;
            commit_v_q    <= '0;
            rollback_q    <= 1'b0;
            target_pc_q   <= '0;
        end else begin
            entries_q     <= entries_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            commit_flag_q <= commit_flag_d;
            commit_rd_q   <= commit_rd_d;
            commit_tag_q  <= commit_tag_d;
            commit_v_q    <= commit_v_d;
            rollback_q    <= rollback_d;
            target_pc_q   <= target_pc_d;
        end
    end

    assign full_to_dispatcher     = full;
    assign Q_to_dispatcher        = idx_to_tag(tail_q);
    assign commit_flag_to_regfile = commit_flag_q;
    assign rd_to_regfile          = commit_rd_q;
    assign Q_to_regfile           = commit_tag_q;
    assign V_to_regfile           = commit_v_q;
    assign rollback_flag_to_all   = rollback_q;
    assign target_pc_to_fetch     = target_pc_q;

    rob_query u_query1 (
        .query_tag_i (Q1_query_from_dispatcher),
        .entries_i   (entries_q),
        .wb_flag_i   (wb_flag_from_cdb),
        .wb_tag_i    (wb_Q_from_cdb),
        .wb_v_i      (wb_V_from_cdb),
        .ready_o     (ready1_to_dispatcher),
        .v_o         (V1_to_dispatcher)
    );

    rob_query u_query2 (
        .query_tag_i (Q2_query_from_dispatcher),
        .entries_i   (entries_q),
        .wb_flag_i   (wb_flag_from_cdb),
        .wb_tag_i    (wb_Q_from_cdb),
        .wb_v_i      (wb_V_from_cdb),
        .ready_o     (ready2_to_dispatcher),
        .v_o         (V2_to_dispatcher)
    );

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected commits are queued by the stimulus and
// popped by a monitor on every commit pulse; direct checks cover full/tag/query/timing.
module tb_reorder_buffer;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        en = 1'b0;
    logic [4:0]  rd = '0;
    logic        is_br = 1'b0;
    logic        full;
    logic [4:0]  q_disp;
    logic [4:0]  q1 = '0, q2 = '0;
    logic        ready1, ready2;
    logic [31:0] v1, v2;
    logic        wb_flag = 1'b0;
    logic [4:0]  wb_q = '0;
    logic [31:0] wb_v = '0;
    logic        wb_mp = 1'b0;
    logic [31:0] wb_tgt = '0;
    logic        commit_flag;
    logic [4:0]  rd_rf;
    logic [4:0]  q_rf;
    logic [31:0] v_rf;
    logic        rollback;
    logic [31:0] tgt_pc;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [4:0]  tag;
        logic [31:0] v;
        logic        rb;
        logic [31:0] tgt;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk_in = ~clk_in;

    reorder_buffer dut (
        .clk_in                    (clk_in),
        .rst_in                    (rst_in),
        .rdy_in                    (rdy_in),
        .en_signal_from_dispatcher (en),
        .rd_from_dispatcher        (rd),
        .is_branch_from_dispatcher (is_br),
        .full_to_dispatcher        (full),
        .Q_to_dispatcher           (q_disp),
        .Q1_query_from_dispatcher  (q1),
        .Q2_query_from_dispatcher  (q2),
        .ready1_to_dispatcher      (ready1),
        .ready2_to_dispatcher      (ready2),
        .V1_to_dispatcher          (v1),
        .V2_to_dispatcher          (v2),
        .wb_flag_from_cdb          (wb_flag),
        .wb_Q_from_cdb             (wb_q),
        .wb_V_from_cdb             (wb_v),
        .wb_mispredict_from_cdb    (wb_mp),
        .wb_target_pc_from_cdb     (wb_tgt),
        .commit_flag_to_regfile    (commit_flag),
        .rd_to_regfile             (rd_rf),
        .Q_to_regfile              (q_rf),
        .V_to_regfile              (v_rf),
        .rollback_flag_to_all      (rollback),
        .target_pc_to_fetch        (tgt_pc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [4:0] r, input logic [4:0] t, input logic [31:0] v,
                        input logic rb, input logic [31:0] tg);
        exp_t e;
        e.rd = r; e.tag = t; e.v = v; e.rb = rb; e.tgt = tg;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic alloc(input logic [4:0] r, input logic br);
        en = 1'b1; rd = r; is_br = br;
        step();
        en = 1'b0; is_br = 1'b0;
    endtask

    task automatic wb(input logic [4:0] t, input logic [31:0] v, input logic mp,
                      input logic [31:0] tg);
        wb_flag = 1'b1; wb_q = t; wb_v = v; wb_mp = mp; wb_tgt = tg;
        step();
        wb_flag = 1'b0; wb_mp = 1'b0;
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        #1;
        check("rst_full", 32'(full), 32'd0);
        check("rst_q_disp", 32'(q_disp), 32'd1);
        check("rst_commit", 32'(commit_flag), 32'd0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        step();
    endtask

    // Scoreboard monitor: every commit pulse must match the oldest expected retirement.
    always @(negedge clk_in) begin
        if (rst_in) begin
            if (commit_flag) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL commit_unexpected: got tag %0d want no commit", q_rf);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (rd_rf !== e.rd || q_rf !== e.tag || v_rf !== e.v || rollback !== e.rb
                        || (e.rb && tgt_pc !== e.tgt)) begin
                        bad++;
                        $display("FAIL commit: got rd=%0d tag=%0d v=%0h rb=%0b pc=%0h want rd=%0d tag=%0d v=%0h rb=%0b pc=%0h",
                                 rd_rf, q_rf, v_rf, rollback, tgt_pc, e.rd, e.tag, e.v, e.rb, e.tgt);
                    end
                end
            end else if (rollback) begin
                total++;
                bad++;
                $display("FAIL rollback_alone: got rollback=1 want 0 without commit");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state and single instruction round trip.
        do_reset();
        check("reset_v_rf", v_rf, 32'd0);
        check("reset_rollback", 32'(rollback), 32'd0);
        alloc(5'd5, 1'b0);
        check("q_after_alloc", 32'(q_disp), 32'd2);
        push(5'd5, 5'd1, 32'h1234, 1'b0, 32'd0);
        wb(5'd1, 32'h1234, 1'b0, 32'd0);
        check("commit_not_early", 32'(commit_flag), 32'd0);
        step();
        check("commit_latency", 32'(commit_flag), 32'd1);
        step();
        check("commit_pulse", 32'(commit_flag), 32'd0);
        check("empty_after_commit", 32'(full), 32'd0);

        // Fill, drop while full, wrap of tag.
        do_reset();
        for (int i = 1; i <= 16; i++) alloc(5'(i), 1'b0);
        check("full_after_16", 32'(full), 32'd1);
        check("q_wrapped", 32'(q_disp), 32'd1);
        alloc(5'd30, 1'b0);
        check("drop_full", 32'(full), 32'd1);
        check("drop_q", 32'(q_disp), 32'd1);
        push(5'd1, 5'd1, 32'hA1, 1'b0, 32'd0);
        wb(5'd1, 32'hA1, 1'b0, 32'd0);
        step();
        check("full_cleared", 32'(full), 32'd0);
        check("wrap_tag", 32'(q_disp), 32'd1);
        alloc(5'd7, 1'b0);
        check("refull", 32'(full), 32'd1);
        check("q_after_wrap", 32'(q_disp), 32'd2);
        push(5'd2, 5'd2, 32'hA2, 1'b0, 32'd0);
        wb(5'd2, 32'hA2, 1'b0, 32'd0);
        en = 1'b1; rd = 5'd11;
        step();
        en = 1'b0;
        check("full_commit_no_alloc_full", 32'(full), 32'd0);
        check("full_commit_no_alloc_q", 32'(q_disp), 32'd2);
        idle(2);

        // Out-of-order writebacks retire in order on consecutive cycles.
        do_reset();
        for (int i = 1; i <= 3; i++) alloc(5'(i), 1'b0);
        push(5'd1, 5'd1, 32'h11, 1'b0, 32'd0);
        push(5'd2, 5'd2, 32'h22, 1'b0, 32'd0);
        push(5'd3, 5'd3, 32'h33, 1'b0, 32'd0);
        wb(5'd3, 32'h33, 1'b0, 32'd0);
        wb(5'd2, 32'h22, 1'b0, 32'd0);
        wb(5'd1, 32'h11, 1'b0, 32'd0);
        step();
        check("ooo_c1", 32'(commit_flag && q_rf == 5'd1), 32'd1);
        step();
        check("ooo_c2", 32'(commit_flag && q_rf == 5'd2), 32'd1);
        step();
        check("ooo_c3", 32'(commit_flag && q_rf == 5'd3), 32'd1);
        idle(2);

        // Mispredicted branch retires with rollback and flushes younger entries.
        do_reset();
        alloc(5'd1, 1'b0);
        alloc(5'd2, 1'b1);
        alloc(5'd3, 1'b0);
        push(5'd1, 5'd1, 32'd1, 1'b0, 32'd0);
        push(5'd2, 5'd2, 32'd2, 1'b1, 32'h80);
        wb(5'd1, 32'd1, 1'b0, 32'd0);
        wb(5'd2, 32'd2, 1'b1, 32'h80);
        en = 1'b1; rd = 5'd8;
        wb(5'd3, 32'd3, 1'b0, 32'd0);
        en = 1'b0;
        check("rb_flag", 32'(rollback), 32'd1);
        check("rb_target", tgt_pc, 32'h80);
        check("rb_full", 32'(full), 32'd0);
        check("rb_q_disp", 32'(q_disp), 32'd1);
        step();
        check("rb_pulse", 32'(rollback), 32'd0);
        check("rb_no_commit", 32'(commit_flag), 32'd0);
        alloc(5'd9, 1'b0);
        push(5'd9, 5'd1, 32'h99, 1'b0, 32'd0);
        wb(5'd1, 32'h99, 1'b0, 32'd0);
        idle(3);

        // Query lookup with and without same-cycle forwarding.
        do_reset();
        for (int i = 1; i <= 4; i++) alloc(5'(i), 1'b0);
        q1 = 5'd4; q2 = 5'd0;
        #1;
        check("q_not_ready", 32'(ready1), 32'd0);
        check("q_tag0", 32'(ready2), 32'd0);
        wb_flag = 1'b1; wb_q = 5'd4; wb_v = 32'd7;
        #1;
`ifdef ROB_QUERY_FWD_EN
        check("q_fwd_ready", 32'(ready1), 32'd1);
        check("q_fwd_v", v1, 32'd7);
`else
        check("q_nofwd_ready", 32'(ready1), 32'd0);
        check("q_nofwd_v", v1, 32'd0);
`endif
        step();
        wb_flag = 1'b0;
        #1;
        check("q_reg_ready", 32'(ready1), 32'd1);
        check("q_reg_v", v1, 32'd7);
        q2 = 5'd1;
        #1;
        check("q2_busy_not_ready", 32'(ready2), 32'd0);

        // rdy_in low holds a ready head without retiring it.
        push(5'd1, 5'd1, 32'h10, 1'b0, 32'd0);
        push(5'd2, 5'd2, 32'h20, 1'b0, 32'd0);
        push(5'd3, 5'd3, 32'h30, 1'b0, 32'd0);
        push(5'd4, 5'd4, 32'd7, 1'b0, 32'd0);
        wb(5'd1, 32'h10, 1'b0, 32'd0);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("frozen_no_commit", 32'(commit_flag), 32'd0);
        end
        rdy_in = 1'b1;
        step();
        check("unfrozen_commit", 32'(commit_flag && q_rf == 5'd1), 32'd1);
        step();
        check("single_commit", 32'(commit_flag), 32'd0);
        wb(5'd2, 32'h20, 1'b0, 32'd0);
        wb(5'd3, 32'h30, 1'b0, 32'd0);
        idle(5);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
